// File: rtl/ref_sched_pkg.sv
// ---------------------------------------------------------------------------
// ref_sched_pkg
// Shared definitions for the reference-reader burst scheduler:
//   - sched_state_t  : scheduler FSM encoding (IDLE, ISSUE, DRAIN, DONE)
//   - BEAT_BYTES     : bytes per 256-bit data beat
//   - BOUNDARY_BEATS : beats per 4 KB page (AXI bursts must not cross it)
//   - BEAT_CNT_W     : width of block/beat counters
//   - burst_beats()  : size of the next burst for a given position
// ---------------------------------------------------------------------------
package ref_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int BEAT_BYTES     = 32;
    localparam int BOUNDARY_BEATS = 128;
    localparam int BEAT_CNT_W     = 24;

    // min(remaining, max_burst, beats left before the next 4 KB page).
    // beat_in_page is addr[11:5]; at a page start it is 0, so a full
    // max_burst fits.
    function automatic logic [7:0] burst_beats(
        input logic [BEAT_CNT_W-1:0] remaining,
        input logic [6:0]            beat_in_page,
        input int unsigned           max_burst
    );
        logic [7:0] to_boundary;
        logic [7:0] beats;
        to_boundary = 8'(BOUNDARY_BEATS) - {1'b0, beat_in_page};
        beats       = 8'(max_burst);
        if ({{(BEAT_CNT_W-8){1'b0}}, beats} > remaining)
            beats = remaining[7:0];
        if (to_boundary < beats)
            beats = to_boundary;
        return beats;
    endfunction

endpackage

// File: rtl/ref_burst_scheduler_if.sv
// ---------------------------------------------------------------------------
// ref_burst_scheduler_if
// Bundles the command, AXI read-request, AXI read-data and consumer stream
// signals of one reference reader port.
//   modport master : the scheduler itself (drives *_out, samples *_in)
//   modport slave  : the surrounding system / testbench
// Parameter C0_C_S_AXI_ID_WIDTH: AXI ID width; the port-side ID is 2 bits
// narrower.
// ---------------------------------------------------------------------------
interface ref_burst_scheduler_if #(
    parameter int C0_C_S_AXI_ID_WIDTH = 8
) ();

    // Command
    logic [32:0]                      cmd_addr_in;
    logic [23:0]                      cmd_blocks_in;
    logic                             cmd_valid_in;
    logic                             cmd_rdy_out;
    // Burst request
    logic [C0_C_S_AXI_ID_WIDTH-3:0]   rd_id_out;
    logic [32:0]                      rd_addr_out;
    logic [7:0]                       rd_len_out;
    logic                             rd_info_valid_out;
    logic                             rd_info_rdy_in;
    // Returned read data
    logic [255:0]                     rd_data_in;
    logic                             rd_data_valid_in;
    logic                             rd_data_rdy_out;
    // Consumer stream
    logic [255:0]                     data_out;
    logic                             data_valid_out;
    logic                             data_last_out;
    logic                             data_rdy_in;
    // Status
    logic                             done_out;
    logic                             busy_out;

    modport master (
        input  cmd_addr_in, cmd_blocks_in, cmd_valid_in,
        output cmd_rdy_out,
        output rd_id_out, rd_addr_out, rd_len_out, rd_info_valid_out,
        input  rd_info_rdy_in,
        input  rd_data_in, rd_data_valid_in,
        output rd_data_rdy_out,
        output data_out, data_valid_out, data_last_out,
        input  data_rdy_in,
        output done_out, busy_out
    );

    modport slave (
        output cmd_addr_in, cmd_blocks_in, cmd_valid_in,
        input  cmd_rdy_out,
        input  rd_id_out, rd_addr_out, rd_len_out, rd_info_valid_out,
        output rd_info_rdy_in,
        output rd_data_in, rd_data_valid_in,
        input  rd_data_rdy_out,
        input  data_out, data_valid_out, data_last_out,
        output data_rdy_in,
        input  done_out, busy_out
    );

endinterface

// File: rtl/ref_rd_fifo.sv
// ---------------------------------------------------------------------------
// ref_rd_fifo
// Synchronous first-word-fall-through FIFO holding returned read beats.
// rd_data always shows the head entry; a write becomes visible one cycle
// later. Writes when full and reads when empty are ignored.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   wr_en, wr_data push side
//   rd_en, rd_data pop side (rd_data = head)
//   full, empty    status flags
//   count          number of stored entries (0..DEPTH)
// Parameters: WIDTH (data bits), DEPTH (entries, power of 2).
// ---------------------------------------------------------------------------
module ref_rd_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // NOTE: the storage array has no reset; only pointers and count do.
    // Resetting 64x256 flops buys nothing because empty masks the contents.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leave the count unchanged.
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/ref_burst_scheduler.sv
// ---------------------------------------------------------------------------
// ref_burst_scheduler
// Sequences DRAM reads for one reference reader port of the 4-port AXI
// arbiter. A command (start address, block count) is split into AXI bursts
// of at most MAX_BURST beats that never cross a 4 KB page. A burst is only
// requested when the data FIFO has room for every beat already in flight
// plus the new burst, so returned data never backpressures the shared read
// channel. Returned beats are streamed to the Smith-Waterman consumer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : ref_burst_scheduler_if.master (command, burst request,
//                read data, consumer stream, done/busy)
//   stat_bursts_out, stat_stall_cycles_out : only with
//                REF_BURST_SCHED_STATS_EN defined; saturating counters of
//                issued bursts and request stall cycles.
// Optional macro: REF_BURST_SCHED_STATS_EN
// ---------------------------------------------------------------------------
module ref_burst_scheduler
    import ref_sched_pkg::*;
#(
    parameter int          C0_C_S_AXI_ID_WIDTH = 8,
    parameter int unsigned READER_ID           = 0,
    parameter int          MAX_BURST           = 16,
    parameter int          BUF_DEPTH           = 64,
    parameter int          MAX_OUTSTANDING     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ref_burst_scheduler_if.master     bus
`ifdef REF_BURST_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_bursts_out,
    output logic [31:0]               stat_stall_cycles_out
`endif
);

    localparam int ID_W  = C0_C_S_AXI_ID_WIDTH - 2;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int OB_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int LQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    sched_state_t          state_q;
    logic                  cmd_rdy_q;
    logic [32:0]           addr_q;
    logic [BEAT_CNT_W-1:0] remaining_q;
    logic [BEAT_CNT_W-1:0] deliver_q;
    logic                  rd_info_valid_q;
    logic [32:0]           rd_addr_q;
    logic [7:0]            rd_len_q;
    logic                  done_q;
    logic                  ret_en_q;

    logic [CNT_W-1:0]      out_beats_q;
    logic [OB_W-1:0]       out_bursts_q;
    logic [7:0]            len_mem [MAX_OUTSTANDING];
    logic [LQ_AW-1:0]      len_wr_ptr_q;
    logic [LQ_AW-1:0]      len_rd_ptr_q;
    logic [7:0]            beat_cnt_q;

    logic [255:0]          fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic                  cmd_hs;
    logic                  issue_hs;
    logic                  wr_hs;
    logic                  pop;
    logic                  burst_end;
    logic [7:0]            next_beats;
    logic [8:0]            issued_beats;
    logic [BEAT_CNT_W-1:0] remaining_after;
    logic [31:0]           credit_need;
    logic                  credit_ok;
    logic                  rd_data_rdy;
    logic                  unused_addr_lsbs;

    // Byte offset within a beat is meaningless; addresses are beat aligned.
    assign unused_addr_lsbs = &{1'b0, bus.cmd_addr_in[4:0]};

    assign cmd_hs          = cmd_rdy_q & bus.cmd_valid_in;
    assign issue_hs        = rd_info_valid_q & bus.rd_info_rdy_in;
    assign rd_data_rdy     = ret_en_q & ~fifo_full;
    assign wr_hs           = bus.rd_data_valid_in & rd_data_rdy;
    assign pop             = ~fifo_empty & bus.data_rdy_in;
    assign next_beats      = burst_beats(remaining_q, addr_q[11:5], MAX_BURST);
    assign issued_beats    = {1'b0, rd_len_q} + 9'd1;
    assign remaining_after = remaining_q - BEAT_CNT_W'(issued_beats);

    // Everything already stored or still in flight must fit alongside the
    // new burst, otherwise the return path could be forced to stall.
    assign credit_need = 32'(fifo_count) + 32'(out_beats_q) + 32'(next_beats);
    assign credit_ok   = (credit_need <= 32'(BUF_DEPTH)) &&
                         (32'(out_bursts_q) < 32'(MAX_OUTSTANDING));

    // ---------------- Control FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cmd_rdy_q       <= 1'b0;
            addr_q          <= '0;
            remaining_q     <= '0;
            deliver_q       <= '0;
            rd_info_valid_q <= 1'b0;
            rd_addr_q       <= '0;
            rd_len_q        <= '0;
            done_q          <= 1'b0;
        end else begin
            if (cmd_hs)
                deliver_q <= bus.cmd_blocks_in;
            else if (pop)
                deliver_q <= deliver_q - 1'b1;

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_hs) begin
                        cmd_rdy_q   <= 1'b0;
                        addr_q      <= {bus.cmd_addr_in[32:5], 5'b0};
                        remaining_q <= bus.cmd_blocks_in;
                        if (bus.cmd_blocks_in == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end else begin
                        cmd_rdy_q <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // A raised request is frozen until accepted; the next
                    // one is sized from the updated address a cycle later.
                    if (issue_hs) begin
                        rd_info_valid_q <= 1'b0;
                        addr_q          <= addr_q + 33'({issued_beats, 5'b0});
                        remaining_q     <= remaining_after;
                        if (remaining_after == '0)
                            state_q <= ST_DRAIN;
                    end else if (!rd_info_valid_q && credit_ok) begin
                        rd_info_valid_q <= 1'b1;
                        rd_addr_q       <= addr_q;
                        rd_len_q        <= next_beats - 8'd1;
                    end
                end

                ST_DRAIN: begin
                    if (deliver_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    done_q    <= 1'b0;
                    cmd_rdy_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- In-flight accounting ----------------
    // Burst lengths queue in issue order; data returns in the same order
    // because the ID is constant, so the head length marks each burst end.
    always_ff @(posedge clk) begin
        if (issue_hs)
            len_mem[len_wr_ptr_q] <= rd_len_q;
    end

    assign burst_end = wr_hs && (beat_cnt_q == len_mem[len_rd_ptr_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_en_q     <= 1'b0;
            out_beats_q  <= '0;
            out_bursts_q <= '0;
            len_wr_ptr_q <= '0;
            len_rd_ptr_q <= '0;
            beat_cnt_q   <= '0;
        end else begin
            ret_en_q    <= 1'b1;
            out_beats_q <= out_beats_q
                         + (issue_hs ? CNT_W'(issued_beats) : CNT_W'(0))
                         - (wr_hs    ? CNT_W'(1)            : CNT_W'(0));
            out_bursts_q <= out_bursts_q
                          + (issue_hs  ? OB_W'(1) : OB_W'(0))
                          - (burst_end ? OB_W'(1) : OB_W'(0));
            if (issue_hs)
                len_wr_ptr_q <= (len_wr_ptr_q == LQ_AW'(MAX_OUTSTANDING-1))
                                ? '0 : len_wr_ptr_q + 1'b1;
            if (burst_end) begin
                beat_cnt_q   <= '0;
                len_rd_ptr_q <= (len_rd_ptr_q == LQ_AW'(MAX_OUTSTANDING-1))
                                ? '0 : len_rd_ptr_q + 1'b1;
            end else if (wr_hs) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- Data buffer ----------------
    ref_rd_fifo #(
        .WIDTH (256),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_hs),
        .wr_data (bus.rd_data_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef REF_BURST_SCHED_STATS_EN
    logic [31:0] stat_bursts_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bursts_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (issue_hs && (stat_bursts_q != '1))
                stat_bursts_q <= stat_bursts_q + 1'b1;
            if (rd_info_valid_q && !bus.rd_info_rdy_in && (stat_stall_q != '1))
                stat_stall_q <= stat_stall_q + 1'b1;
        end
    end

    assign stat_bursts_out       = stat_bursts_q;
    assign stat_stall_cycles_out = stat_stall_q;
`endif

    // ---------------- Outputs ----------------
    assign bus.cmd_rdy_out       = cmd_rdy_q;
    assign bus.rd_id_out         = ID_W'(READER_ID);
    assign bus.rd_addr_out       = rd_addr_q;
    assign bus.rd_len_out        = rd_len_q;
    assign bus.rd_info_valid_out = rd_info_valid_q;
    assign bus.rd_data_rdy_out   = rd_data_rdy;
    // Head is masked while empty so stale storage never reaches the port.
    assign bus.data_out          = fifo_empty ? '0 : fifo_head;
    assign bus.data_valid_out    = ~fifo_empty;
    assign bus.data_last_out     = ~fifo_empty && (deliver_q == BEAT_CNT_W'(1));
    assign bus.done_out          = done_q;
    assign bus.busy_out          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ref_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ref_burst_scheduler
// Directed bench for ref_burst_scheduler with default parameters
// (MAX_BURST=16, BUF_DEPTH=64, MAX_OUTSTANDING=4). A responder process
// plays the AXI read slave (returns {8{beat_address}} per beat) and the
// consumer; it only logs what it sees. Each test task compares the logs
// and sampled outputs against hand-computed values. All inputs change and
// all outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ref_burst_scheduler;

    typedef struct {
        logic [32:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ref_burst_scheduler_if #(.C0_C_S_AXI_ID_WIDTH(8)) bus ();

`ifdef REF_BURST_SCHED_STATS_EN
    logic [31:0] stat_bursts;
    logic [31:0] stat_stalls;
`endif

    ref_burst_scheduler #(
        .C0_C_S_AXI_ID_WIDTH (8),
        .READER_ID           (0),
        .MAX_BURST           (16),
        .BUF_DEPTH           (64),
        .MAX_OUTSTANDING     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef REF_BURST_SCHED_STATS_EN
        ,
        .stat_bursts_out       (stat_bursts),
        .stat_stall_cycles_out (stat_stalls)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Responder controls and logs
    bit           info_rdy_en = 1'b1;
    bit           cons_en     = 1'b1;
    burst_t       inflight[$];
    int           beat_idx    = 0;
    burst_t       log_burst[$];
    logic [255:0] log_data[$];
    logic         log_last[$];
    int           done_cnt     = 0;
    int           valid_cycles = 0;
    int           rdy_drop_cnt = 0;

    function automatic logic [255:0] pat(input logic [32:0] a);
        return {8{a[31:0]}};
    endfunction

    // AXI read slave + consumer model
    initial begin
        burst_t b;
        bus.rd_info_rdy_in   = 1'b0;
        bus.rd_data_valid_in = 1'b0;
        bus.rd_data_in       = '0;
        bus.data_rdy_in      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight.delete();
                beat_idx             = 0;
                bus.rd_info_rdy_in   = 1'b0;
                bus.rd_data_valid_in = 1'b0;
                bus.data_rdy_in      = 1'b0;
            end else begin
                // Data for bursts accepted on earlier edges only.
                if (inflight.size() > 0) begin
                    bus.rd_data_valid_in = 1'b1;
                    bus.rd_data_in = pat(inflight[0].addr + 33'(beat_idx * 32));
                    if (!bus.rd_data_rdy_out) begin
                        rdy_drop_cnt++;
                    end else if (beat_idx == int'(inflight[0].len)) begin
                        beat_idx = 0;
                        void'(inflight.pop_front());
                    end else begin
                        beat_idx++;
                    end
                end else begin
                    bus.rd_data_valid_in = 1'b0;
                end
                bus.rd_info_rdy_in = info_rdy_en;
                if (bus.rd_info_valid_out)
                    valid_cycles++;
                if (bus.rd_info_valid_out && bus.rd_info_rdy_in) begin
                    b.addr = bus.rd_addr_out;
                    b.len  = bus.rd_len_out;
                    inflight.push_back(b);
                    log_burst.push_back(b);
                end
                bus.data_rdy_in = cons_en;
                if (bus.data_valid_out && bus.data_rdy_in) begin
                    log_data.push_back(bus.data_out);
                    log_last.push_back(bus.data_last_out);
                end
                if (bus.done_out)
                    done_cnt++;
            end
        end
    end

    task automatic clear_logs();
        @(posedge clk);
        log_burst.delete();
        log_data.delete();
        log_last.delete();
        done_cnt     = 0;
        valid_cycles = 0;
        rdy_drop_cnt = 0;
    endtask

    task automatic send_cmd(input logic [32:0] addr, input logic [23:0] blocks);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_rdy_out) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL cmd_rdy_timeout: cmd_rdy_out=%0b want 1 within 50 cycles", bus.cmd_rdy_out);
        end
        bus.cmd_addr_in   = addr;
        bus.cmd_blocks_in = blocks;
        bus.cmd_valid_in  = 1'b1;
        @(negedge clk);
        bus.cmd_valid_in  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done_timeout: no done_out within %0d cycles", name, budget);
        end
        @(negedge clk);
        n_vec++;
        if (done_cnt !== 1 || bus.busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done_pulse: done pulses=%0d busy=%0b want 1 pulse, busy 0",
                     name, done_cnt, bus.busy_out);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.cmd_addr_in   = '0;
        bus.cmd_blocks_in = '0;
        bus.cmd_valid_in  = 1'b0;
        #2;
        n_vec++;
        if ({bus.cmd_rdy_out, bus.rd_info_valid_out, bus.rd_data_rdy_out,
             bus.data_valid_out, bus.data_last_out, bus.done_out, bus.busy_out} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: rdy=%0b iv=%0b drdy=%0b dv=%0b last=%0b done=%0b busy=%0b want all 0",
                     bus.cmd_rdy_out, bus.rd_info_valid_out, bus.rd_data_rdy_out,
                     bus.data_valid_out, bus.data_last_out, bus.done_out, bus.busy_out);
        end
        n_vec++;
        if (bus.rd_addr_out !== 33'h0 || bus.rd_len_out !== 8'h0 ||
            bus.data_out !== 256'h0 || bus.rd_id_out !== 6'h0) begin
            n_err++;
            $display("FAIL reset_buses: addr=%h len=%h id=%h data=%h want 0",
                     bus.rd_addr_out, bus.rd_len_out, bus.rd_id_out, bus.data_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.cmd_rdy_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.rd_data_rdy_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: cmd_rdy=%0b busy=%0b rd_data_rdy=%0b want 1,0,1",
                     bus.cmd_rdy_out, bus.busy_out, bus.rd_data_rdy_out);
        end
    endtask

    // 40 blocks from 0x0: (0x0,15) (0x200,15) (0x400,7); last on beat 40.
    task automatic test_basic();
        logic [32:0] ea [3] = '{33'h0, 33'h200, 33'h400};
        logic [7:0]  el [3] = '{8'd15, 8'd15, 8'd7};
        clear_logs();
        send_cmd(33'h0, 24'd40);
        wait_done("basic", 500);
        n_vec++;
        if (log_burst.size() !== 3) begin
            n_err++;
            $display("FAIL basic_burst_count: got %0d want 3", log_burst.size());
        end
        for (int k = 0; k < 3 && k < log_burst.size(); k++) begin
            n_vec++;
            if (log_burst[k].addr !== ea[k] || log_burst[k].len !== el[k]) begin
                n_err++;
                $display("FAIL basic_burst%0d: got (%h,%0d) want (%h,%0d)",
                         k, log_burst[k].addr, log_burst[k].len, ea[k], el[k]);
            end
        end
        n_vec++;
        if (log_data.size() !== 40) begin
            n_err++;
            $display("FAIL basic_beat_count: got %0d want 40", log_data.size());
        end
        for (int k = 0; k < 40 && k < log_data.size(); k++) begin
            n_vec++;
            if (log_data[k] !== pat(33'(k * 32)) || log_last[k] !== (k == 39)) begin
                n_err++;
                $display("FAIL basic_beat%0d: data=%h last=%0b want data=%h last=%0b",
                         k, log_data[k], log_last[k], pat(33'(k * 32)), (k == 39));
            end
        end
    endtask

    // 4 blocks at 0xFC0 split at the 4 KB page: (0xFC0,1) (0x1000,1).
    task automatic test_boundary();
        logic [32:0] ea [2] = '{33'hFC0, 33'h1000};
        clear_logs();
        send_cmd(33'hFC0, 24'd4);
        wait_done("boundary", 300);
        n_vec++;
        if (log_burst.size() !== 2) begin
            n_err++;
            $display("FAIL boundary_burst_count: got %0d want 2", log_burst.size());
        end
        for (int k = 0; k < 2 && k < log_burst.size(); k++) begin
            n_vec++;
            if (log_burst[k].addr !== ea[k] || log_burst[k].len !== 8'd1) begin
                n_err++;
                $display("FAIL boundary_burst%0d: got (%h,%0d) want (%h,1)",
                         k, log_burst[k].addr, log_burst[k].len, ea[k]);
            end
        end
        n_vec++;
        if (log_data.size() !== 4) begin
            n_err++;
            $display("FAIL boundary_beat_count: got %0d want 4", log_data.size());
        end
        for (int k = 0; k < 4 && k < log_data.size(); k++) begin
            n_vec++;
            if (log_data[k] !== pat(33'hFC0 + 33'(k * 32)) || log_last[k] !== (k == 3)) begin
                n_err++;
                $display("FAIL boundary_beat%0d: data=%h last=%0b want data=%h last=%0b",
                         k, log_data[k], log_last[k], pat(33'hFC0 + 33'(k * 32)), (k == 3));
            end
        end
    endtask

    task automatic test_zero_blocks();
        clear_logs();
        send_cmd(33'h4000, 24'd0);
        wait_done("zero", 20);
        n_vec++;
        if (valid_cycles !== 0 || log_data.size() !== 0) begin
            n_err++;
            $display("FAIL zero_no_burst: valid cycles=%0d beats=%0d want 0,0",
                     valid_cycles, log_data.size());
        end
    endtask

    // Request held for 10 cycles: (0x2000,15) must not move.
    task automatic test_info_stall();
        bit seen = 1'b0;
        clear_logs();
        info_rdy_en = 1'b0;
        send_cmd(33'h2000, 24'd20);
        for (int i = 0; i < 20; i++) begin
            if (bus.rd_info_valid_out) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL stall_valid_timeout: rd_info_valid_out never rose within 20 cycles");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.rd_info_valid_out !== 1'b1 || bus.rd_addr_out !== 33'h2000 ||
                bus.rd_len_out !== 8'd15) begin
                n_err++;
                $display("FAIL stall_hold_c%0d: valid=%0b addr=%h len=%0d want 1,2000,15",
                         c, bus.rd_info_valid_out, bus.rd_addr_out, bus.rd_len_out);
            end
        end
        @(posedge clk);
        info_rdy_en = 1'b1;
        wait_done("stall", 300);
        n_vec++;
        if (log_burst.size() !== 2 ||
            log_burst[0].addr !== 33'h2000 || log_burst[0].len !== 8'd15 ||
            log_burst[1].addr !== 33'h2200 || log_burst[1].len !== 8'd3) begin
            n_err++;
            $display("FAIL stall_bursts: count=%0d want (2000,15),(2200,3)", log_burst.size());
        end
        n_vec++;
        if (log_data.size() !== 20 || log_last[19] !== 1'b1 || log_data[19] !== pat(33'h2260)) begin
            n_err++;
            $display("FAIL stall_beats: count=%0d want 20 ending at 2260 with last", log_data.size());
        end
    endtask

    // Consumer stalled: credit caps issue at 64 beats; resumes afterwards.
    task automatic test_credit();
        int issued;
        clear_logs();
        cons_en = 1'b0;
        send_cmd(33'h0, 24'd200);
        repeat (150) @(negedge clk);
        issued = 0;
        foreach (log_burst[k]) issued += int'(log_burst[k].len) + 1;
        n_vec++;
        if (issued !== 64) begin
            n_err++;
            $display("FAIL credit_cap: issued %0d beats want 64", issued);
        end
        n_vec++;
        if (bus.data_valid_out !== 1'b1 || bus.busy_out !== 1'b1 || log_data.size() !== 0) begin
            n_err++;
            $display("FAIL credit_hold: data_valid=%0b busy=%0b popped=%0d want 1,1,0",
                     bus.data_valid_out, bus.busy_out, log_data.size());
        end
        @(posedge clk);
        cons_en = 1'b1;
        wait_done("credit", 3000);
        issued = 0;
        foreach (log_burst[k]) issued += int'(log_burst[k].len) + 1;
        n_vec++;
        if (issued !== 200 || log_burst.size() !== 13) begin
            n_err++;
            $display("FAIL credit_total: issued %0d beats in %0d bursts want 200 in 13",
                     issued, log_burst.size());
        end
        n_vec++;
        if (rdy_drop_cnt !== 0) begin
            n_err++;
            $display("FAIL credit_rdy_drop: rd_data_rdy_out low on %0d data cycles want 0", rdy_drop_cnt);
        end
        n_vec++;
        if (log_data.size() !== 200) begin
            n_err++;
            $display("FAIL credit_beat_count: got %0d want 200", log_data.size());
        end
        for (int k = 0; k < 200 && k < log_data.size(); k++) begin
            if (log_data[k] !== pat(33'(k * 32)) || log_last[k] !== (k == 199)) begin
                n_vec++;
                n_err++;
                $display("FAIL credit_beat%0d: data=%h last=%0b want data=%h last=%0b",
                         k, log_data[k], log_last[k], pat(33'(k * 32)), (k == 199));
            end
        end
        n_vec++;
        if (log_data.size() == 200 && (log_last[199] !== 1'b1 || log_last[198] !== 1'b0)) begin
            n_err++;
            $display("FAIL credit_last: last[198]=%0b last[199]=%0b want 0,1", log_last[198], log_last[199]);
        end
    endtask

    task automatic test_reset_mid_drain();
        int issued;
        clear_logs();
        cons_en = 1'b0;
        send_cmd(33'h0, 24'd40);
        repeat (100) @(negedge clk);
        issued = 0;
        foreach (log_burst[k]) issued += int'(log_burst[k].len) + 1;
        n_vec++;
        if (issued !== 40 || bus.busy_out !== 1'b1 || bus.data_valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL drain_setup: issued=%0d busy=%0b dv=%0b want 40,1,1",
                     issued, bus.busy_out, bus.data_valid_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.cmd_rdy_out, bus.rd_info_valid_out, bus.rd_data_rdy_out, bus.data_valid_out,
             bus.data_last_out, bus.done_out, bus.busy_out} !== 7'b0 ||
            bus.data_out !== 256'h0 || bus.rd_addr_out !== 33'h0 || bus.rd_len_out !== 8'h0) begin
            n_err++;
            $display("FAIL drain_async_reset: rdy=%0b iv=%0b drdy=%0b dv=%0b busy=%0b data=%h addr=%h want all 0",
                     bus.cmd_rdy_out, bus.rd_info_valid_out, bus.rd_data_rdy_out,
                     bus.data_valid_out, bus.busy_out, bus.data_out, bus.rd_addr_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        cons_en = 1'b1;
        send_cmd(33'h100, 24'd2);
        wait_done("post_reset", 200);
        n_vec++;
        if (log_burst.size() !== 1 || log_burst[0].addr !== 33'h100 || log_burst[0].len !== 8'd1) begin
            n_err++;
            $display("FAIL post_reset_burst: count=%0d want one (100,1)", log_burst.size());
        end
        n_vec++;
        if (log_data.size() !== 2 || log_data[0] !== pat(33'h100) || log_data[1] !== pat(33'h120) ||
            log_last[0] !== 1'b0 || log_last[1] !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_beats: count=%0d want 2 beats 100,120 with last on second",
                     log_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_zero_blocks();
        test_info_stall();
        test_credit();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
